// File: rtl/rv32_mem_arbiter_pkg.sv
// rv32 memory arbiter shared types.
// Optional fairness: RV32_MEM_ARBITER_FAIR_EN.
package rv32_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  typedef enum logic {
    OWNER_INSTR,
    OWNER_DATA
  } owner_e;

  localparam int MASK_W    = 4;
  localparam int STARVE_W  = 4;
  localparam int STARVE_MAX = 15;

endpackage

// File: rtl/rv32_mem_arbiter_pick.sv
// Winner selection between fetch and data ports.
// RV32_MEM_ARBITER_FAIR_EN adds a starvation guard for fetch.
module rv32_mem_arbiter_pick
  import rv32_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   instr_valid_i,
  input  logic   data_valid_i,
  input  logic   grant_i,
  output owner_e owner_o
);

`ifdef RV32_MEM_ARBITER_FAIR_EN
  logic [STARVE_W-1:0] cnt_q;
  logic                starve;

  assign starve  = instr_valid_i &&
                   (cnt_q == STARVE_W'(STARVE_LIMIT));
  assign owner_o = (data_valid_i && !starve) ?
                   OWNER_DATA : OWNER_INSTR;

  // Counts data grants that left a waiting fetch behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (grant_i) begin
      if (owner_o == OWNER_INSTR) begin
        cnt_q <= '0;
      end else if (instr_valid_i &&
                   cnt_q != STARVE_W'(STARVE_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_pick;

  assign owner_o = data_valid_i ? OWNER_DATA : OWNER_INSTR;
  assign unused_pick = ^{clk, reset_n, instr_valid_i,
                         grant_i, 4'(STARVE_LIMIT)};
`endif

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Single-bus arbiter for rv32 fetch and load/store ports.
// Fetch starvation guard: RV32_MEM_ARBITER_FAIR_EN.
module rv32_mem_arbiter
  import rv32_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid_in,
  input  logic [31:0]       instr_address_in,
  output logic              instr_ready_out,
  output logic              instr_rvalid_out,
  output logic [31:0]       instr_rdata_out,
  input  logic              data_valid_in,
  input  logic              data_write_in,
  input  logic [31:0]       data_address_in,
  input  logic [31:0]       data_write_value_in,
  input  logic [MASK_W-1:0] data_write_mask_in,
  output logic              data_ready_out,
  output logic              data_rvalid_out,
  output logic [31:0]       data_rdata_out,
  output logic              mem_valid_out,
  input  logic              mem_ready_in,
  output logic              mem_write_out,
  output logic [31:0]       mem_address_out,
  output logic [31:0]       mem_write_value_out,
  output logic [MASK_W-1:0] mem_write_mask_out,
  input  logic              mem_rvalid_in,
  input  logic [31:0]       mem_rdata_in
);

  state_e              state_q;
  owner_e              own_q;
  owner_e              pick_own;
  logic                write_q;
  logic [31:0]         addr_q;
  logic [31:0]         wval_q;
  logic [MASK_W-1:0]   mask_q;
  logic                mvalid_q;
  logic                i_rvalid_q;
  logic                d_rvalid_q;
  logic [31:0]         i_rdata_q;
  logic [31:0]         d_rdata_q;
  logic                req_any;
  logic                grant;

  assign req_any = instr_valid_in | data_valid_in;
  assign grant   = reset_n && (state_q == IDLE) && req_any;

  rv32_mem_arbiter_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_valid_i (instr_valid_in),
    .data_valid_i  (data_valid_in),
    .grant_i       (grant),
    .owner_o       (pick_own)
  );

  assign instr_ready_out = grant && (pick_own == OWNER_INSTR);
  assign data_ready_out  = grant && (pick_own == OWNER_DATA);

  assign instr_rvalid_out    = i_rvalid_q;
  assign instr_rdata_out     = i_rdata_q;
  assign data_rvalid_out     = d_rvalid_q;
  assign data_rdata_out      = d_rdata_q;
  assign mem_valid_out       = mvalid_q;
  assign mem_write_out       = write_q;
  assign mem_address_out     = addr_q;
  assign mem_write_value_out = wval_q;
  assign mem_write_mask_out  = mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      own_q      <= OWNER_INSTR;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wval_q     <= '0;
      mask_q     <= '0;
      mvalid_q   <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_any) begin
            if (pick_own == OWNER_DATA) begin
              own_q   <= OWNER_DATA;
              write_q <= data_write_in;
              addr_q  <= data_address_in;
              wval_q  <= data_write_value_in;
              mask_q  <= data_write_mask_in;
            end else begin
              own_q   <= OWNER_INSTR;
              write_q <= 1'b0;
              addr_q  <= instr_address_in;
              wval_q  <= '0;
              mask_q  <= '0;
            end
            mvalid_q <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (mem_ready_in) begin
            mvalid_q <= 1'b0;
            state_q  <= write_q ? IDLE : RESP;
          end
        end
        RESP: begin
          // Response goes back to whoever issued the read.
          if (mem_rvalid_in) begin
            if (own_q == OWNER_DATA) begin
              d_rdata_q  <= mem_rdata_in;
              d_rvalid_q <= 1'b1;
            end else begin
              i_rdata_q  <= mem_rdata_in;
              i_rvalid_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed self-checking bench for rv32_mem_arbiter.
// Grant-order expectations follow RV32_MEM_ARBITER_FAIR_EN.
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid_in;
  logic [31:0] instr_address_in;
  logic        instr_ready_out;
  logic        instr_rvalid_out;
  logic [31:0] instr_rdata_out;
  logic        data_valid_in;
  logic        data_write_in;
  logic [31:0] data_address_in;
  logic [31:0] data_write_value_in;
  logic [3:0]  data_write_mask_in;
  logic        data_ready_out;
  logic        data_rvalid_out;
  logic [31:0] data_rdata_out;
  logic        mem_valid_out;
  logic        mem_ready_in;
  logic        mem_write_out;
  logic [31:0] mem_address_out;
  logic [31:0] mem_write_value_out;
  logic [3:0]  mem_write_mask_out;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;

  int checks = 0;
  int errors = 0;
  logic exp_i [6];

  always #5 clk = ~clk;

  rv32_mem_arbiter #(
    .STARVE_LIMIT (2)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .instr_valid_in      (instr_valid_in),
    .instr_address_in    (instr_address_in),
    .instr_ready_out     (instr_ready_out),
    .instr_rvalid_out    (instr_rvalid_out),
    .instr_rdata_out     (instr_rdata_out),
    .data_valid_in       (data_valid_in),
    .data_write_in       (data_write_in),
    .data_address_in     (data_address_in),
    .data_write_value_in (data_write_value_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_ready_out      (data_ready_out),
    .data_rvalid_out     (data_rvalid_out),
    .data_rdata_out      (data_rdata_out),
    .mem_valid_out       (mem_valid_out),
    .mem_ready_in        (mem_ready_in),
    .mem_write_out       (mem_write_out),
    .mem_address_out     (mem_address_out),
    .mem_write_value_out (mem_write_value_out),
    .mem_write_mask_out  (mem_write_mask_out),
    .mem_rvalid_in       (mem_rvalid_in),
    .mem_rdata_in        (mem_rdata_in)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_irdy"}, instr_ready_out, 0);
    chk({tag, "_drdy"}, data_ready_out, 0);
    chk({tag, "_irv"}, instr_rvalid_out, 0);
    chk({tag, "_drv"}, data_rvalid_out, 0);
    chk({tag, "_ird"}, instr_rdata_out, 0);
    chk({tag, "_drd"}, data_rdata_out, 0);
    chk({tag, "_mv"}, mem_valid_out, 0);
    chk({tag, "_mw"}, mem_write_out, 0);
    chk({tag, "_ma"}, mem_address_out, 0);
    chk({tag, "_mwv"}, mem_write_value_out, 0);
    chk({tag, "_mm"}, {28'd0, mem_write_mask_out}, 0);
  endtask

  initial begin
`ifdef RV32_MEM_ARBITER_FAIR_EN
    exp_i = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    reset_n             = 1'b0;
    instr_valid_in      = 1'b0;
    instr_address_in    = '0;
    data_valid_in       = 1'b0;
    data_write_in       = 1'b0;
    data_address_in     = '0;
    data_write_value_in = '0;
    data_write_mask_in  = '0;
    mem_ready_in        = 1'b0;
    mem_rvalid_in       = 1'b0;
    mem_rdata_in        = '0;
    #12;
    all_zero("rst");
    #10 reset_n = 1'b1;
    tick;

    // Instruction read, zero-wait bus
    instr_valid_in   = 1'b1;
    instr_address_in = 32'h100;
    #1;
    chk("t1_irdy", instr_ready_out, 1);
    chk("t1_drdy", data_ready_out, 0);
    tick;
    instr_valid_in = 1'b0;
    chk("t1_mv", mem_valid_out, 1);
    chk("t1_ma", mem_address_out, 32'h100);
    chk("t1_mw", mem_write_out, 0);
    chk("t1_mm", {28'd0, mem_write_mask_out}, 0);
    mem_ready_in = 1'b1;
    tick;
    mem_ready_in  = 1'b0;
    chk("t1_mv2", mem_valid_out, 0);
    chk("t1_irv_early", instr_rvalid_out, 0);
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = 32'hDEADBEEF;
    tick;
    mem_rvalid_in = 1'b0;
    chk("t1_irv", instr_rvalid_out, 1);
    chk("t1_ird", instr_rdata_out, 32'hDEADBEEF);
    chk("t1_drv", data_rvalid_out, 0);
    tick;
    chk("t1_irv_pulse", instr_rvalid_out, 0);
    chk("t1_drv2", data_rvalid_out, 0);

    // Both valid, data store wins
    data_valid_in       = 1'b1;
    data_write_in       = 1'b1;
    data_address_in     = 32'h40;
    data_write_value_in = 32'h12345678;
    data_write_mask_in  = 4'b0011;
    instr_valid_in      = 1'b1;
    instr_address_in    = 32'h200;
    #1;
    chk("t2_drdy", data_ready_out, 1);
    chk("t2_irdy", instr_ready_out, 0);
    tick;
    data_valid_in = 1'b0;
    data_write_in = 1'b0;
    #1;
    chk("t2_irdy_req", instr_ready_out, 0);
    chk("t2_mv", mem_valid_out, 1);
    chk("t2_mw", mem_write_out, 1);
    chk("t2_mm", {28'd0, mem_write_mask_out}, 3);
    chk("t2_ma", mem_address_out, 32'h40);
    chk("t2_mwv", mem_write_value_out, 32'h12345678);
    mem_ready_in = 1'b1;
    tick;
    mem_ready_in = 1'b0;
    #1;
    chk("t2_irdy_c2", instr_ready_out, 1);
    chk("t2_mv_c2", mem_valid_out, 0);
    tick;
    instr_valid_in = 1'b0;
    chk("t2_ma_i", mem_address_out, 32'h200);
    chk("t2_mw_i", mem_write_out, 0);
    chk("t2_mm_i", {28'd0, mem_write_mask_out}, 0);
    mem_ready_in = 1'b1;
    tick;
    mem_ready_in  = 1'b0;
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = 32'hCAFEF00D;
    tick;
    mem_rvalid_in = 1'b0;
    chk("t2_irv", instr_rvalid_out, 1);
    chk("t2_ird", instr_rdata_out, 32'hCAFEF00D);
    chk("t2_drv", data_rvalid_out, 0);

    // Store with three bus wait cycles
    data_valid_in       = 1'b1;
    data_write_in       = 1'b1;
    data_address_in     = 32'h80;
    data_write_value_in = 32'hAAAA5555;
    data_write_mask_in  = 4'b1111;
    #1;
    chk("t3_drdy", data_ready_out, 1);
    tick;
    data_valid_in = 1'b0;
    data_write_in = 1'b0;
    for (int w = 0; w < 3; w++) begin
      chk("t3_wait_mv", mem_valid_out, 1);
      chk("t3_wait_ma", mem_address_out, 32'h80);
      chk("t3_wait_mwv", mem_write_value_out, 32'hAAAA5555);
      tick;
    end
    mem_ready_in = 1'b1;
    chk("t3_ma_hs", mem_address_out, 32'h80);
    tick;
    mem_ready_in    = 1'b0;
    data_valid_in   = 1'b1;
    data_address_in = 32'h84;
    #1;
    chk("t3_drdy_c5", data_ready_out, 1);
    tick;
    data_valid_in = 1'b0;
    chk("t3_mw_load", mem_write_out, 0);
    mem_ready_in = 1'b1;
    tick;
    mem_ready_in  = 1'b0;
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = 32'h0BADCAFE;
    tick;
    mem_rvalid_in = 1'b0;
    chk("t3_drv", data_rvalid_out, 1);
    chk("t3_drd", data_rdata_out, 32'h0BADCAFE);
    chk("t3_ird_hold", instr_rdata_out, 32'hCAFEF00D);
    chk("t3_irv", instr_rvalid_out, 0);

    // Stray bus response while idle
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = 32'hFFFFFFFF;
    tick;
    mem_rvalid_in = 1'b0;
    chk("t6_irv", instr_rvalid_out, 0);
    chk("t6_drv", data_rvalid_out, 0);
    tick;
    chk("t6_irv2", instr_rvalid_out, 0);
    chk("t6_drv2", data_rvalid_out, 0);
    chk("t6_ird", instr_rdata_out, 32'hCAFEF00D);
    chk("t6_drd", data_rdata_out, 32'h0BADCAFE);
    chk("t6_mv", mem_valid_out, 0);

    // Grant order with both ports always valid
    instr_valid_in      = 1'b1;
    instr_address_in    = 32'h300;
    data_valid_in       = 1'b1;
    data_write_in       = 1'b1;
    data_address_in     = 32'h44;
    data_write_mask_in  = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      data_write_value_in = i;
      #1;
      chk("t4_grant_i", instr_ready_out, exp_i[i]);
      chk("t4_grant_d", data_ready_out, !exp_i[i]);
      tick;
      mem_ready_in = 1'b1;
      tick;
      mem_ready_in = 1'b0;
      if (exp_i[i]) begin
        mem_rvalid_in = 1'b1;
        mem_rdata_in  = i;
        tick;
        mem_rvalid_in = 1'b0;
      end
    end
    instr_valid_in = 1'b0;
    data_valid_in  = 1'b0;
    data_write_in  = 1'b0;
    tick;

    // Reset during RESP drops the response
    instr_valid_in   = 1'b1;
    instr_address_in = 32'h500;
    #1;
    chk("t5_irdy", instr_ready_out, 1);
    tick;
    instr_valid_in = 1'b0;
    mem_ready_in   = 1'b1;
    tick;
    mem_ready_in = 1'b0;
    reset_n      = 1'b0;
    #1;
    all_zero("t5_rst");
    #3 reset_n = 1'b1;
    tick;
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = 32'h55AA55AA;
    tick;
    mem_rvalid_in = 1'b0;
    chk("t5_irv", instr_rvalid_out, 0);
    chk("t5_drv", data_rvalid_out, 0);
    tick;
    chk("t5_irv2", instr_rvalid_out, 0);
    chk("t5_ird", instr_rdata_out, 0);
    chk("t5_mv", mem_valid_out, 0);
    data_valid_in   = 1'b1;
    data_write_in   = 1'b0;
    data_address_in = 32'h600;
    #1;
    chk("t5_idle_drdy", data_ready_out, 1);
    tick;
    data_valid_in = 1'b0;
    chk("t5_ma", mem_address_out, 32'h600);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Shares one single-ported memory bus between the instruction-fetch port and the data (load/store) port of the rv32 pipeline. It handles one outstanding transaction at a time using valid/ready handshakes on each side, and routes each read response back to the requester that issued it. By default the data port has priority; an optional starvation guard keeps instruction fetch making progress.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while instruction fetch waits. Range 1–15. Used only with the fairness macro.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr_valid_in  in  1  fetch request
- instr_address_in  in  32  fetch byte address
- instr_ready_out  out  1  fetch request accepted this cycle
- instr_rvalid_out  out  1  fetch read data valid, one-cycle pulse
- instr_rdata_out  out  32  fetch read data
- data_valid_in  in  1  load/store request
- data_write_in  in  1  1 = store, 0 = load
- data_address_in  in  32  load/store byte address
- data_write_value_in  in  32  store data
- data_write_mask_in  in  4  store byte enables
- data_ready_out  out  1  load/store request accepted this cycle
- data_rvalid_out  out  1  load data valid, one-cycle pulse
- data_rdata_out  out  32  load data
- mem_valid_out  out  1  bus request
- mem_ready_in  in  1  bus accepts the request
- mem_write_out  out  1  bus write
- mem_address_out  out  32  bus address
- mem_write_value_out  out  32  bus write data
- mem_write_mask_out  out  4  bus byte enables
- mem_rvalid_in  in  1  bus read data valid
- mem_rdata_in  in  32  bus read data

## Operation
- FSM states:
  - IDLE: may accept a new request.
  - REQ: drives the bus request.
  - RESP: waits for read data.
- IDLE:
  - If any *_valid_in is high, pick a winner and pulse its *_ready_out combinationally.
  - Capture the winner's address, write flag, value, mask and owner into registers, then go to REQ.
  - Instruction requests always capture write=0 and mask=4'b0000.
- REQ:
  - mem_valid_out=1 and mem_* outputs come from the captured registers, held stable until mem_ready_in.
  - On mem_ready_in with a write: go to IDLE. Stores produce no response.
  - On mem_ready_in with a read: go to RESP.
- RESP: on mem_rvalid_in, register mem_rdata_in into the owner's *_rdata_out, pulse the owner's *_rvalid_out on the next cycle, and go to IDLE.
- *_rdata_out holds its value until the next response to the same owner.
- Ready outputs are low in REQ and RESP. Requesters must hold valid and payload until ready.
- mem_rvalid_in outside RESP is ignored.
- Both valids in IDLE: the data port wins unless the starvation guard fires (see Configuration).
- Reset (async assert, any state):
  - FSM goes to IDLE; in-flight responses are dropped.
  - All outputs go to 0: ready, rvalid and mem_valid_out low; rdata, address, value and mask zero.
  - Starve counter clears to 0.

## Timing
- Read, zero-wait bus: accept at cycle 0, mem_valid_out and mem_ready_in at cycle 1, mem_rvalid_in at cycle 2, *_rvalid_out at cycle 3.
- Write, zero-wait bus: accept at cycle 0, bus handshake at cycle 1, next accept possible at cycle 2.
- Each bus wait cycle (mem_ready_in low) or response wait cycle adds exactly one cycle.
- Maximum accept rate: one request per two cycles for writes, one per three cycles for reads.

## Configuration
- RV32_MEM_ARBITER_FAIR_EN defined:
  - A 4-bit starve counter increments on each data grant made while instr_valid_in is high.
  - When the counter equals STARVE_LIMIT and both ports are valid, instruction fetch wins and the counter clears.
  - An instruction grant always clears the counter.
  - The counter saturates at 15 and never wraps.
- Macro undefined: strict data priority; no counter is built and STARVE_LIMIT is unused.

## Structure
- Package rv32_mem_arbiter_pkg holds:
  - state enum: IDLE, REQ, RESP
  - owner enum: OWNER_INSTR, OWNER_DATA
  - the mask-width localparam
- Sub-module rv32_mem_arbiter_pick contains the winner selection and the starve counter (clk, reset_n, both valids, grant strobe, owner out).
- The FSM, capture registers and response routing stay in the top module.

## Test plan
- Instruction read only, address 0x100, mem_rdata_in 0xDEADBEEF, zero-wait bus -> instr_rvalid_out pulses at cycle 3 with instr_rdata_out 0xDEADBEEF; data_rvalid_out never asserts.
- Both ports valid at once, data store to 0x40 with mask 4'b0011 -> data_ready_out first; mem_write_out=1 and mem_write_mask_out=4'b0011; instruction fetch accepted at cycle 2.
- mem_ready_in held low for 3 cycles during REQ -> mem_address_out and mem_write_value_out stay stable; accept delayed by exactly 3 cycles.
- With RV32_MEM_ARBITER_FAIR_EN and STARVE_LIMIT=2, both ports always valid -> grant order data, data, instr, data, data, instr. Without the macro -> the data port always wins.
- reset_n asserted during RESP, then a stray mem_rvalid_in after release -> no rvalid pulse; all outputs 0; FSM in IDLE.
- mem_rvalid_in pulsed while in IDLE -> ignored; no rvalid output; rdata outputs unchanged.
